// File: rtl/register_file_16_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared constants, types and helpers for the register file and
//               the datapath blocks around it.
// Contents    : NUM_REGS, REG_ADDR_W, DATA_W, reg_addr_t, data_t, sel_vec_t,
//               is_multi_hot()
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned DATA_W     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [NUM_REGS-1:0]   sel_vec_t;

    // True when two or more bits are set. Clearing the lowest set bit leaves
    // something behind only if another bit was set as well.
    function automatic logic is_multi_hot(input sel_vec_t v);
        return (v & (v - sel_vec_t'(1))) != '0;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/register_file_16_if.sv
`default_nettype none
// ============================================================================
// Interface   : register_file_16_if
// Description : Write/read bus between the decode/ALU side and the register
//               file.
// Signals     : select_line   one-hot write enables (bit i -> register i)
//               c_data        write data (C bus)
//               a_addr/b_addr read addresses for ports A and B
//               err_clr       synchronous clear of the multi-select flag
//               a_data/b_data combinational read data
//               multi_sel_err sticky multi-hot select flag
// Modports    : master (driver side), slave (register file side)
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_16_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
);
    sel_vec_t          select_line;
    logic [WIDTH-1:0]  c_data;
    reg_addr_t         a_addr;
    reg_addr_t         b_addr;
    logic              err_clr;
    logic [WIDTH-1:0]  a_data;
    logic [WIDTH-1:0]  b_data;
    logic              multi_sel_err;

    modport master (
        output select_line, c_data, a_addr, b_addr, err_clr,
        input  a_data, b_data, multi_sel_err
    );

    modport slave (
        input  select_line, c_data, a_addr, b_addr, err_clr,
        output a_data, b_data, multi_sel_err
    );

endinterface : register_file_16_if
`default_nettype wire

// File: rtl/register_file_16_reg_cell.sv
`default_nettype none
// ============================================================================
// Module      : reg_cell
// Description : One WIDTH-bit storage register with load enable and
//               asynchronous active-high reset to RESET_VALUE.
// Ports       : clk     rising-edge clock
//               reset   asynchronous active-high reset
//               load_en load d on the next rising edge
//               d       data in
//               q       stored value
// Revision    : 1.0 - initial release
// ============================================================================
module reg_cell
    import cpu_pkg::*;
#(
    parameter int unsigned       WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load_en,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] value_d;
    logic [WIDTH-1:0] value_q;

    always_comb begin
        value_d = value_q;
        if (load_en) begin
            value_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= RESET_VALUE;
        end else begin
            value_q <= value_d;
        end
    end

    assign q = value_q;

endmodule : reg_cell
`default_nettype wire

// File: rtl/register_file_16.sv
`default_nettype none
// ============================================================================
// Module      : register_file_16
// Description : 16-entry general-purpose register file. Writes c_data into
//               every register selected by the one-hot select_line, offers
//               two combinational read ports (optionally write-through), and
//               keeps a sticky flag for multi-hot select vectors.
// Ports       : clk    rising-edge clock
//               reset  asynchronous active-high reset
//               bus    register_file_16_if.slave (select_line, c_data,
//                      a_addr, b_addr, err_clr -> a_data, b_data,
//                      multi_sel_err)
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_16
    import cpu_pkg::*;
#(
    parameter int unsigned       WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       BYPASS      = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    register_file_16_if.slave bus
);

    logic [WIDTH-1:0] reg_q [NUM_REGS];

    logic             a_hit;
    logic             b_hit;
    logic [WIDTH-1:0] a_rd;
    logic [WIDTH-1:0] b_rd;

    logic             multi_hot;
    logic             multi_sel_err_d;
    logic             multi_sel_err_q;

    // ------------------------------------------------------------------
    // Storage: one cell per register, write enable straight from the
    // decoder. A multi-hot vector simply writes every selected cell.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        reg_cell #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .load_en (bus.select_line[gi]),
            .d       (bus.c_data),
            .q       (reg_q[gi])
        );
    end

    // ------------------------------------------------------------------
    // Write-through detection: a port hits when the register it reads is
    // being written this cycle.
    // ------------------------------------------------------------------
    if (BYPASS != 0) begin : g_bypass
        assign a_hit = bus.select_line[bus.a_addr];
        assign b_hit = bus.select_line[bus.b_addr];
    end else begin : g_no_bypass
        assign a_hit = 1'b0;
        assign b_hit = 1'b0;
    end

    // Read ports
    always_comb begin
        a_rd = reg_q[bus.a_addr];
        b_rd = reg_q[bus.b_addr];
        if (a_hit) begin
            a_rd = bus.c_data;
        end
        if (b_hit) begin
            b_rd = bus.c_data;
        end
    end

    assign bus.a_data = a_rd;
    assign bus.b_data = b_rd;

    // ------------------------------------------------------------------
    // Sticky multi-select flag. A new violation outranks a clear in the
    // same cycle so that no event can be silently dropped.
    // ------------------------------------------------------------------
    assign multi_hot = is_multi_hot(bus.select_line);

    always_comb begin
        multi_sel_err_d = multi_sel_err_q;
        if (multi_hot) begin
            multi_sel_err_d = 1'b1;
        end else if (bus.err_clr) begin
            multi_sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            multi_sel_err_q <= 1'b0;
        end else begin
            multi_sel_err_q <= multi_sel_err_d;
        end
    end

    assign bus.multi_sel_err = multi_sel_err_q;

endmodule : register_file_16
`default_nettype wire

// File: tb/tb_register_file_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_16
// Description : Self-checking bench for register_file_16. Two instances run
//               side by side on the same stimulus, one write-through and one
//               not, and are compared against an array-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_16;
    import cpu_pkg::*;

    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_file_16_if #(.WIDTH(WIDTH)) bus_byp ();
    register_file_16_if #(.WIDTH(WIDTH)) bus_nob ();

    // Both instances see the same inputs
    assign bus_nob.select_line = bus_byp.select_line;
    assign bus_nob.c_data      = bus_byp.c_data;
    assign bus_nob.a_addr      = bus_byp.a_addr;
    assign bus_nob.b_addr      = bus_byp.b_addr;
    assign bus_nob.err_clr     = bus_byp.err_clr;

    register_file_16 #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0),
        .BYPASS      (1)
    ) u_dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_byp.slave)
    );

    register_file_16 #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0),
        .BYPASS      (0)
    ) u_dut_nob (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nob.slave)
    );

    // Reference state
    logic [WIDTH-1:0] m_regs [NUM_REGS];
    logic             m_err;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_read(input int addr, input bit bypass);
        if (bypass && bus_byp.select_line[addr] === 1'b1) return bus_byp.c_data;
        return m_regs[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_err = 1'b0;
    endtask

    // Applies the rules of one rising edge to the reference state
    task automatic model_edge();
        int cnt;
        cnt = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus_byp.select_line[i]) begin
                m_regs[i] = bus_byp.c_data;
                cnt++;
            end
        end
        if (cnt >= 2)                m_err = 1'b1;
        else if (bus_byp.err_clr)    m_err = 1'b0;
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_a_byp"}, bus_byp.a_data, exp_read(int'(bus_byp.a_addr), 1'b1));
        chk({tag, "_b_byp"}, bus_byp.b_data, exp_read(int'(bus_byp.b_addr), 1'b1));
        chk({tag, "_a_nob"}, bus_nob.a_data, exp_read(int'(bus_byp.a_addr), 1'b0));
        chk({tag, "_b_nob"}, bus_nob.b_data, exp_read(int'(bus_byp.b_addr), 1'b0));
    endtask

    task automatic check_err(input string tag);
        chk1({tag, "_err_byp"}, bus_byp.multi_sel_err, m_err);
        chk1({tag, "_err_nob"}, bus_nob.multi_sel_err, m_err);
    endtask

    // Reads every address on both ports with no write pending
    task automatic check_all(input string tag);
        bus_byp.select_line = '0;
        bus_byp.err_clr     = 1'b0;
        for (int a = 0; a < NUM_REGS; a++) begin
            bus_byp.a_addr = reg_addr_t'(a);
            bus_byp.b_addr = reg_addr_t'(NUM_REGS - 1 - a);
            #1;
            check_reads(tag);
        end
        check_err(tag);
    endtask

    // One clocked operation: drive at the falling edge, check reads before
    // the rising edge, then advance the reference and check again after it.
    task automatic step(input sel_vec_t sel, input logic [WIDTH-1:0] c,
                        input int a, input int b, input logic clr, input string tag);
        @(negedge clk);
        bus_byp.select_line = sel;
        bus_byp.c_data      = c;
        bus_byp.a_addr      = reg_addr_t'(a);
        bus_byp.b_addr      = reg_addr_t'(b);
        bus_byp.err_clr     = clr;
        #1;
        check_reads({tag, "_pre"});
        @(posedge clk);
        model_edge();
        #1;
        check_reads({tag, "_post"});
        check_err(tag);
    endtask

    initial begin
        sel_vec_t sel;
        int       r;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus_byp.select_line = '0;
        bus_byp.c_data      = '0;
        bus_byp.a_addr      = '0;
        bus_byp.b_addr      = '0;
        bus_byp.err_clr     = 1'b0;

        // Asynchronous reset raised between clock edges
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Write sweep, one register per cycle
        for (int i = 0; i < NUM_REGS; i++) begin
            step(sel_vec_t'(1) << i, WIDTH'(16'h1000 + i), i, (i + 1) % NUM_REGS, 1'b0, "sweep");
        end
        check_all("sweep_all");

        // Write-through on port A, port B on a neighbouring register
        step(16'h0020, 16'hBEEF, 5, 4, 1'b0, "bypass");
        check_all("bypass_all");

        // Multi-hot broadcast sets the flag; a later clear drops it
        step(16'h0101, 16'hA5A5, 0, 8, 1'b0, "multi");
        check_all("multi_all");
        step(16'h0000, WIDTH'($urandom), 0, 8, 1'b1, "clr");

        // Set and clear in the same cycle: set wins
        step(16'h0003, WIDTH'($urandom), 0, 1, 1'b1, "set_wins");
        step(16'h0000, WIDTH'($urandom), 2, 3, 1'b1, "clr2");

        // Reset held across a write edge: the write is lost
        @(negedge clk);
        bus_byp.select_line = 16'h8000;
        bus_byp.c_data      = 16'h1234;
        bus_byp.a_addr      = 4'd15;
        bus_byp.b_addr      = 4'd15;
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        bus_byp.select_line = '0;
        reset = 1'b0;
        #1;
        check_all("rst_write");

        // Randomised traffic: mostly one-hot, some idle, some multi-hot
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      sel = '0;
            else if (r < 8) sel = sel_vec_t'(1) << $urandom_range(0, NUM_REGS - 1);
            else            sel = sel_vec_t'($urandom);
            step(sel, WIDTH'($urandom), int'($urandom_range(0, NUM_REGS - 1)),
                 int'($urandom_range(0, NUM_REGS - 1)), ($urandom_range(0, 3) == 0), "rand");
        end
        check_all("rand_all");

        // Idle: no select, random data on the C bus
        step(16'h0000, WIDTH'($urandom), 0, 0, 1'b1, "idle_clr");
        for (int n = 0; n < 100; n++) begin
            step(16'h0000, WIDTH'($urandom), int'($urandom_range(0, NUM_REGS - 1)),
                 int'($urandom_range(0, NUM_REGS - 1)), 1'b0, "idle");
        end
        check_all("idle_all");
        chk1("idle_flag_low", bus_byp.multi_sel_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_file_16
`default_nettype wire

// File: doc/register_file_16.md
Name: register_file_16

Overview:
- 16-entry general-purpose register file.
- Consumes the 16-bit one-hot load-enable vector from the destination-register decoder (C-address decode stage) and writes the shared C-bus data into every selected register on the clock edge.
- Provides two independent combinational read ports (A and B) feeding the ALU operand buses.
- Flags illegal multi-hot select vectors with a sticky error bit for debug.

Parameters:
- WIDTH, 16: data width of each register and of the C, A and B buses.
- RESET_VALUE, 0: value loaded into every register on reset (WIDTH bits).
- BYPASS, 1: 1 = a read port whose address is being written in the same cycle returns c_data (write-through); 0 = it returns the stored (old) value.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- select_line  input  16  one-hot write enables from the decoder; bit i writes register i; all-zero means no write.
- c_data  input  WIDTH  write data (C bus).
- a_addr  input  4  read address, port A.
- b_addr  input  4  read address, port B.
- err_clr  input  1  synchronous clear of multi_sel_err.
- a_data  output  WIDTH  contents of register a_addr (combinational).
- b_data  output  WIDTH  contents of register b_addr (combinational).
- multi_sel_err  output  1  sticky flag: a select_line with two or more bits set was seen.

Behaviour:
- Reset (reset=1, asynchronous, no clock needed):
  - All 16 registers take RESET_VALUE.
  - multi_sel_err goes to 0.
  - a_data and b_data therefore read RESET_VALUE.
  - Reset asserted mid-write wins; the write is lost.
- Write: on each rising clk edge with reset=0, every register i with select_line[i]=1 loads c_data. Other registers hold. Write latency is 1 cycle; new data is visible from registers after the edge.
- Multi-hot select:
  - All selected registers are still written (broadcast).
  - At the same edge, multi_sel_err <= 1.
- Zero select: no register changes; not an error.
- Reads:
  - Purely combinational, zero cycles.
  - a_data = R[a_addr] and b_data = R[b_addr].
  - Both ports may address the same register, with identical output.
- Bypass:
  - BYPASS=1: if select_line[a_addr]=1, a_data = c_data in the same cycle; same rule for port B.
  - BYPASS=0: the old value is visible until the edge.
- Error flag:
  - Set condition: popcount(select_line) >= 2 at a clock edge.
  - Clear condition: err_clr=1 at a clock edge.
  - Set and clear in the same cycle: set wins, flag stays 1.
  - Otherwise the flag holds.
- No internal state besides the 16 registers and multi_sel_err. No X propagation: every addressed read is defined after reset.
- Width rules: c_data is stored unmodified with no sign extension. Addresses are exactly 4 bits, so there is no out-of-range case.

Decomposition:
- Shared package (cpu_pkg):
  - NUM_REGS = 16
  - REG_ADDR_W = 4
  - DATA_W default 16
  - typedef reg_addr_t (4 bits)
  - typedef data_t (DATA_W bits)
- Sub-module reg_cell:
  - One WIDTH-bit register with load enable, async active-high reset to RESET_VALUE.
  - Instantiated 16 times via generate.
- Read muxes, bypass compare and popcount/error logic live in the top level.

Test Plan:
1. Reset with reset=1 at arbitrary mid-cycle time -> a_data=b_data=0x0000 for all a_addr/b_addr 0..15; multi_sel_err=0.
2. Write sweep: for i=0..15 drive select_line=1<<i, c_data=0x1000+i for one cycle, then read all addresses -> R[i]=0x1000+i on both ports; no cross-writes.
3. BYPASS=1 with select_line=0x0020, c_data=0xBEEF, a_addr=5, b_addr=4 (R[4]=0x1004) -> a_data=0xBEEF before the edge, b_data=0x1004. BYPASS=0 with the same stimulus -> a_data=0x1005 until the edge, then 0xBEEF.
4. Multi-hot select_line=0x0101, c_data=0xA5A5 -> R[0]=R[8]=0xA5A5 and multi_sel_err=1 after the edge. Next cycle err_clr=1 with select_line=0 -> flag returns to 0.
5. Simultaneous events: err_clr=1 together with select_line=0x0003 -> multi_sel_err stays 1. Separately, assert reset during a write with select_line=0x8000, c_data=0x1234 -> R[15]=0x0000 after reset.
6. Idle: select_line=0 with random c_data for 100 cycles -> all registers unchanged; multi_sel_err=0.
